// File: rtl/ififo_ctrl_pkg.sv
// Shared types and default sizing for the input-FIFO loader controller.
package ififo_ctrl_pkg;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned ROW_DEF   = 8;
  localparam int unsigned DEPTH_DEF = 64;
  localparam int unsigned AW_DEF    = 11;
  localparam int unsigned CW_DEF    = cnt_width(DEPTH_DEF);

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StDrain,
    StFlush,
    StDone
  } state_e;

endpackage

// File: rtl/sram_rd_agen.sv
// SRAM read address generator: issues one read per enabled, non-stalled cycle and
// produces the matching FIFO write strobe one cycle later (1-cycle SRAM latency).
module sram_rd_agen #(
  parameter int unsigned AW = 11,
  parameter int unsigned CW = 7
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [AW-1:0] i_base_addr,
  input  logic [CW-1:0] i_num,
  input  logic          i_issue_en,
  input  logic          i_ififo_full,
  output logic          o_sram_cen,
  output logic [AW-1:0] o_sram_addr,
  output logic          o_ififo_wr
);

  logic [AW-1:0] r_base;
  logic [CW-1:0] r_num;
  logic [CW-1:0] r_issued;
  logic          r_wr;
  logic          w_issue;

  assign w_issue = i_issue_en && (r_issued < r_num) && !i_ififo_full;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_base   <= '0;
      r_num    <= '0;
      r_issued <= '0;
      r_wr     <= 1'b0;
    end else begin
      if (i_load) begin
        r_base   <= i_base_addr;
        r_num    <= i_num;
        r_issued <= '0;
      end else if (w_issue) begin
        r_issued <= r_issued + CW'(1);
      end
      r_wr <= w_issue;
    end
  end

  // Address wraps naturally at 2^AW; a stall leaves r_issued and hence the address unchanged.
  assign o_sram_addr = r_base + AW'(r_issued);
  assign o_sram_cen  = !w_issue;
  assign o_ififo_wr  = r_wr;

endmodule

// File: rtl/ififo_loader_ctrl.sv
// Tile sequencer for the per-row input FIFO bank: FILL from activation SRAM,
// DRAIN into the PE array, FLUSH the row skew, then pulse done.
module ififo_loader_ctrl
  import ififo_ctrl_pkg::*;
#(
  parameter int unsigned ROW   = ROW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned CW    = cnt_width(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [CW-1:0] i_num_vec,
  input  logic [AW-1:0] i_base_addr,
  output logic          o_sram_cen,
  output logic          o_sram_wen,
  output logic [AW-1:0] o_sram_addr,
  output logic          o_ififo_wr,
  input  logic          i_ififo_full,
  input  logic          i_array_ready,
  output logic          o_ififo_rd,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  localparam int unsigned FW = (ROW > 2) ? $clog2(ROW - 1) : 1;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [CW-1:0] r_num;
  logic [CW-1:0] r_wr_cnt;
  logic [CW-1:0] r_rd_cnt;
  logic [FW-1:0] r_flush_cnt;
  logic          r_err;
  logic [CW-1:0] w_num_clamp;
  logic          w_accept;
  logic          w_issue_en;
  logic          w_wr;
  logic          w_rd;
  logic          w_last_wr;
  logic          w_last_rd;
  logic          w_flush_end;

  assign w_num_clamp = (i_num_vec > CW'(DEPTH)) ? CW'(DEPTH) : i_num_vec;
  assign w_accept    = (r_state == StIdle) && i_start;
  assign w_last_wr   = w_wr && (r_wr_cnt == r_num - CW'(1));
  assign w_last_rd   = w_rd && (r_rd_cnt == r_num - CW'(1));
  assign w_flush_end = (r_flush_cnt == FW'(ROW - 2));

  sram_rd_agen #(
    .AW (AW),
    .CW (CW)
  ) u_agen (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_load       (w_accept),
    .i_base_addr  (i_base_addr),
    .i_num        (w_num_clamp),
    .i_issue_en   (w_issue_en),
    .i_ififo_full (i_ififo_full),
    .o_sram_cen   (o_sram_cen),
    .o_sram_addr  (o_sram_addr),
    .o_ififo_wr   (w_wr)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_nxt = (w_num_clamp == '0) ? StDone : StFill;
      StFill:  if (w_last_wr) w_state_nxt = StDrain;
      StDrain: if (w_last_rd) w_state_nxt = StFlush;
      StFlush: if (w_flush_end) w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_issue_en = 1'b0;
    w_rd       = 1'b0;
    o_busy     = 1'b1;
    o_done     = 1'b0;
    unique case (r_state)
      StIdle:  o_busy = 1'b0;
      StFill:  w_issue_en = 1'b1;
      StDrain: w_rd = i_array_ready;
      StFlush: ;
      StDone:  o_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_num       <= '0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_flush_cnt <= '0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      r_num       <= w_num_clamp;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_flush_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_wr) r_wr_cnt <= r_wr_cnt + CW'(1);
      if (w_rd) r_rd_cnt <= r_rd_cnt + CW'(1);
      if (r_state == StFlush) r_flush_cnt <= r_flush_cnt + FW'(1);
      // A write landing while the bank reports full loses that vector.
      if (w_wr && i_ififo_full) r_err <= 1'b1;
    end
  end

  assign o_sram_wen = 1'b1;
  assign o_ififo_wr = w_wr;
  assign o_ififo_rd = w_rd;
  assign o_err      = r_err;

endmodule

// File: tb/tb_ififo_loader_ctrl.sv
// Directed bench for ififo_loader_ctrl with an SRAM-address scoreboard and per-cycle monitor.
module tb_ififo_loader_ctrl;

  localparam int unsigned ROW = 8;
  localparam int unsigned AW  = 11;
  localparam int unsigned CW  = 7;

  logic          clk;
  logic          rst_n;
  logic          i_start;
  logic [CW-1:0] i_num_vec;
  logic [AW-1:0] i_base_addr;
  logic          o_sram_cen;
  logic          o_sram_wen;
  logic [AW-1:0] o_sram_addr;
  logic          o_ififo_wr;
  logic          i_ififo_full;
  logic          i_array_ready;
  logic          o_ififo_rd;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  int            n_cmp;
  int            n_fail;
  int            cyc;
  int            start_cyc;
  int            done_cyc;
  int            first_cen_cyc;
  int            last_rd_cyc;
  int            cnt_wr;
  int            cnt_rd;
  int            cnt_done;
  logic          prev_iss;
  logic [AW-1:0] exp_q[$];

  ififo_loader_ctrl u_dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (i_start),
    .i_num_vec     (i_num_vec),
    .i_base_addr   (i_base_addr),
    .o_sram_cen    (o_sram_cen),
    .o_sram_wen    (o_sram_wen),
    .o_sram_addr   (o_sram_addr),
    .o_ififo_wr    (o_ififo_wr),
    .i_ififo_full  (i_ififo_full),
    .i_array_ready (i_array_ready),
    .o_ififo_rd    (o_ififo_rd),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pops expected SRAM addresses, checks write delay and wr/rd exclusivity.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_iss = 1'b0;
    end else begin
      if (!o_sram_cen) begin
        n_cmp++;
        assert (exp_q.size() > 0) else begin
          n_fail++;
          $error("FAIL extra_issue: observed addr 0x%0h expected no issue", o_sram_addr);
        end
        if (exp_q.size() > 0) chk("sram_addr", 32'(o_sram_addr), 32'(exp_q.pop_front()));
        if (first_cen_cyc < 0) first_cen_cyc = cyc;
      end
      chk("wr_delay", 32'(o_ififo_wr), 32'(prev_iss));
      chk("wr_rd_excl", 32'(o_ififo_wr & o_ififo_rd), 32'(0));
      chk("sram_wen", 32'(o_sram_wen), 32'(1));
      if (o_ififo_wr) cnt_wr++;
      if (o_ififo_rd) begin
        cnt_rd++;
        last_rd_cyc = cyc;
      end
      if (o_done) cnt_done++;
      prev_iss = !o_sram_cen;
    end
  end

  function automatic int clamp_n(input int n);
    return (n > 64) ? 64 : n;
  endfunction

  // Queue expected addresses, then pulse start for one cycle starting now.
  task automatic kick(input int n, input int base);
    for (int i = 0; i < clamp_n(n); i++) exp_q.push_back(AW'(base + i));
    cnt_wr = 0;
    cnt_rd = 0;
    cnt_done = 0;
    first_cen_cyc = -1;
    last_rd_cyc = -1;
    i_num_vec = CW'(n);
    i_base_addr = AW'(base);
    i_start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic run(input int lo, input int hi, input bit tog, input int sa, input int sb,
                     input int budget);
    int k;
    k = 0;
    while (!o_done && k < budget) begin
      i_ififo_full = (k >= lo) && (k < hi);
      i_array_ready = tog ? !k[0] : 1'b1;
      i_start = (k == sa) || (k == sb);
      @(posedge clk); #1;
      k++;
    end
    i_ififo_full = 1'b0;
    i_start = 1'b0;
    i_array_ready = 1'b1;
    done_cyc = cyc;
    chk("done_seen", 32'(o_done), 32'(1));
    chk("busy_in_done", 32'(o_busy), 32'(1));
  endtask

  task automatic after_done(input int n);
    @(posedge clk); #1;
    chk("busy_idle", 32'(o_busy), 32'(0));
    chk("done_once", 32'(o_done), 32'(0));
    chk("wr_count", 32'(cnt_wr), 32'(clamp_n(n)));
    chk("rd_count", 32'(cnt_rd), 32'(clamp_n(n)));
    chk("done_count", 32'(cnt_done), 32'(1));
    chk("addr_q_empty", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    prev_iss = 1'b0;
    rst_n = 1'b0;
    i_start = 1'b0;
    i_num_vec = '0;
    i_base_addr = '0;
    i_ififo_full = 1'b0;
    i_array_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cen", 32'(o_sram_cen), 32'(1));
    chk("rst_addr", 32'(o_sram_addr), 32'(0));
    chk("rst_wr", 32'(o_ififo_wr), 32'(0));
    chk("rst_rd", 32'(o_ififo_rd), 32'(0));
    chk("rst_busy", 32'(o_busy), 32'(0));
    chk("rst_done", 32'(o_done), 32'(0));
    chk("rst_err", 32'(o_err), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic tile: N=4 at 0x010, no stalls.
    kick(4, 'h010);
    run(0, 0, 1'b0, -1, -1, 200);
    chk("basic_first_cen", 32'(first_cen_cyc), 32'(start_cyc + 1));
    chk("basic_flush_len", 32'(done_cyc - last_rd_cyc), 32'(ROW));
    chk("basic_latency", 32'(done_cyc - start_cyc), 32'(1 + 5 + 4 + (ROW - 1)));
    chk("basic_err", 32'(o_err), 32'(0));
    after_done(4);

    // Backpressure: full for 3 cycles mid-FILL, array_ready toggling in DRAIN.
    kick(8, 'h080);
    run(3, 6, 1'b1, -1, -1, 300);
    after_done(8);

    // N=0: done the cycle after start is sampled, no activity.
    kick(0, 'h123);
    run(0, 0, 1'b0, -1, -1, 20);
    chk("n0_done_lat", 32'(done_cyc), 32'(start_cyc + 1));
    after_done(0);

    // N=64 wrapping past the top of the address space.
    kick(64, 'h7F0);
    run(0, 0, 1'b0, -1, -1, 400);
    chk("wrap_latency", 32'(done_cyc - start_cyc), 32'(1 + 65 + 64 + (ROW - 1)));
    after_done(64);

    // N=100 clamps to 64.
    kick(100, 'h300);
    run(0, 0, 1'b0, -1, -1, 400);
    after_done(100);

    // Overflow: full asserted in the cycle of the first write.
    kick(4, 'h100);
    run(1, 2, 1'b0, -1, -1, 200);
    chk("ovf_err_done", 32'(o_err), 32'(1));
    after_done(4);
    chk("ovf_err_idle", 32'(o_err), 32'(1));
    kick(2, 'h140);
    chk("ovf_err_clear", 32'(o_err), 32'(0));
    run(0, 0, 1'b0, -1, -1, 200);
    after_done(2);

    // Reset mid-DRAIN with the array stalled.
    kick(8, 'h200);
    i_array_ready = 1'b0;
    repeat (11) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_wr", 32'(cnt_wr), 32'(8));
    chk("pre_rst_busy", 32'(o_busy), 32'(1));
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cen", 32'(o_sram_cen), 32'(1));
    chk("mid_rst_addr", 32'(o_sram_addr), 32'(0));
    chk("mid_rst_wr", 32'(o_ififo_wr), 32'(0));
    chk("mid_rst_rd", 32'(o_ififo_rd), 32'(0));
    chk("mid_rst_busy", 32'(o_busy), 32'(0));
    chk("mid_rst_done", 32'(o_done), 32'(0));
    chk("mid_rst_err", 32'(o_err), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    i_array_ready = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
    end
    chk("post_rst_done", 32'(cnt_done), 32'(0));
    chk("post_rst_rd", 32'(cnt_rd), 32'(0));
    chk("post_rst_busy", 32'(o_busy), 32'(0));
    kick(3, 'h020);
    run(0, 0, 1'b0, -1, -1, 200);
    after_done(3);

    // Starts in FILL (k=2) and DRAIN (k=7) are ignored; start held across DONE->IDLE.
    kick(4, 'h040);
    run(0, 0, 1'b0, 2, 7, 200);
    i_start = 1'b1;
    @(posedge clk); #1;
    chk("b2b_idle_busy", 32'(o_busy), 32'(0));
    chk("b2b_wr_count", 32'(cnt_wr), 32'(4));
    chk("b2b_rd_count", 32'(cnt_rd), 32'(4));
    chk("b2b_done_count", 32'(cnt_done), 32'(1));
    kick(2, 'h050);
    chk("b2b_busy", 32'(o_busy), 32'(1));
    run(0, 0, 1'b0, -1, -1, 200);
    after_done(2);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
